// File: rtl/pipelined_main_memory.sv
// Word-addressed main memory with a hardware zero-init sweep after reset and a READ_LATENCY-deep read pipeline.
// Optional byte-masked writes: define PIPELINED_MAIN_MEMORY_BYTE_WRITE_EN.
module pipelined_main_memory #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 2048,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rd_req_valid,
  output logic                    rd_req_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rd_resp_valid,
  output logic [DATA_WIDTH-1:0]   rd_resp_data,
  output logic                    rd_resp_err,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_byte_en,
  output logic                    init_busy
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BYTES = DATA_WIDTH / 8;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        init_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    run;
  logic                    init_wr;
  logic                    rd_fire, wr_fire;
  logic                    rd_in_range, wr_in_range;
  logic [IDX_W-1:0]        rd_idx, wr_idx;

  logic [READ_LATENCY-1:0] vld_p;
  logic [DATA_WIDTH-1:0]   data_p [READ_LATENCY];
  logic                    err_p  [READ_LATENCY];

`ifdef PIPELINED_MAIN_MEMORY_BYTE_WRITE_EN
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BYTES-1:0]      be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < BYTES; b++)
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    return res;
  endfunction
`else
  logic unused_byte_en;
  assign unused_byte_en = ^wr_byte_en;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) init_cnt <= init_cnt + IDX_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      ST_INIT: if (init_cnt == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
      ST_RUN:  run = 1'b1;
      default: state_d = ST_INIT;
    endcase
  end

  // Handshakes are masked by rst so nothing is accepted in the reset cycle.
  assign rd_req_ready = run && !rst;
  assign wr_ready     = run && !rst;
  assign init_busy    = !run || rst;
  assign init_wr      = (state_q == ST_INIT) && !rst;

  assign rd_fire     = rd_req_valid && rd_req_ready;
  assign wr_fire     = wr_valid && wr_ready;
  assign rd_in_range = rd_addr < ADDR_WIDTH'(DEPTH);
  assign wr_in_range = wr_addr < ADDR_WIDTH'(DEPTH);
  assign rd_idx      = rd_addr[IDX_W-1:0];
  assign wr_idx      = wr_addr[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[init_cnt] <= '0;
    end else if (wr_fire && wr_in_range) begin
`ifdef PIPELINED_MAIN_MEMORY_BYTE_WRITE_EN
      mem[wr_idx] <= merge_bytes(mem[wr_idx], wr_data, wr_byte_en);
`else
      mem[wr_idx] <= wr_data;
`endif
    end
  end

  // p0: array read in the accepting cycle (sees pre-write contents, i.e. read-first)
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= rd_fire;
      for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    data_p[0] <= rd_in_range ? mem[rd_idx] : '0;
    err_p[0]  <= !rd_in_range;
    for (int i = 1; i < READ_LATENCY; i++) begin
      data_p[i] <= data_p[i-1];
      err_p[i]  <= err_p[i-1];
    end
  end

  // Last stage: data/err are forced to zero outside a response cycle.
  assign rd_resp_valid = vld_p[READ_LATENCY-1] && !rst;
  assign rd_resp_data  = rd_resp_valid ? data_p[READ_LATENCY-1] : '0;
  assign rd_resp_err   = rd_resp_valid && err_p[READ_LATENCY-1];

endmodule

// File: tb/tb_pipelined_main_memory.sv
// Randomized bench for pipelined_main_memory against a cycle-indexed array/queue reference model.
module tb_pipelined_main_memory;
  localparam int DW    = 32;
  localparam int DEPTH = 2048;
  localparam int AW    = 32;
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req_valid, rd_req_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_resp_valid;
  logic [DW-1:0] rd_resp_data;
  logic          rd_resp_err;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_byte_en;
  logic          init_busy;

  pipelined_main_memory #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr),
    .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data), .rd_resp_err(rd_resp_err),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint        due;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  logic [DW-1:0] ref_mem [DEPTH];
  rsp_t          exp_q [$];
  longint        cyc = 0;
  int            since_rst = 0;
  int            total = 0;
  int            bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: compare outputs against the model, then advance the model.
  task automatic tick();
    bit   exp_run;
    rsp_t r;
    @(negedge clk);
    if (rst) begin
      chk("rst_rd_ready", rd_req_ready, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_busy", init_busy, 1);
      chk("rst_resp_valid", rd_resp_valid, 0);
      chk("rst_resp_data", rd_resp_data, 0);
      chk("rst_resp_err", rd_resp_err, 0);
      exp_q.delete();
      since_rst = 0;
      foreach (ref_mem[i]) ref_mem[i] = '0;
    end else begin
      exp_run = (since_rst >= DEPTH);
      chk("rd_ready", rd_req_ready, exp_run);
      chk("wr_ready", wr_ready, exp_run);
      chk("init_busy", init_busy, !exp_run);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        r = exp_q.pop_front();
        chk("resp_valid", rd_resp_valid, 1);
        chk("resp_data", rd_resp_data, r.data);
        chk("resp_err", rd_resp_err, r.err);
      end else begin
        chk("idle_valid", rd_resp_valid, 0);
        chk("idle_data", rd_resp_data, 0);
        chk("idle_err", rd_resp_err, 0);
      end
      if (exp_run && rd_req_valid) begin
        r.due  = cyc + LAT;
        r.err  = (rd_addr >= DEPTH);
        r.data = r.err ? '0 : ref_mem[rd_addr[10:0]];
        exp_q.push_back(r);
      end
      if (exp_run && wr_valid && wr_addr < DEPTH) begin
`ifdef PIPELINED_MAIN_MEMORY_BYTE_WRITE_EN
        for (int b = 0; b < 4; b++)
          if (wr_byte_en[b]) ref_mem[wr_addr[10:0]][8*b +: 8] = wr_data[8*b +: 8];
`else
        ref_mem[wr_addr[10:0]] = wr_data;
`endif
      end
      if (!exp_run) since_rst++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input bit rv, input logic [AW-1:0] ra, input bit wv,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [3:0] be);
    rd_req_valid = rv;
    rd_addr      = ra;
    wr_valid     = wv;
    wr_addr      = wa;
    wr_data      = wd;
    wr_byte_en   = be;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0, '0, '0, 4'hF);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    case ($urandom_range(0, 9))
      0:       return AW'(DEPTH);
      1:       return 32'hFFFF_FFFF;
      2:       return 32'd4096 + $urandom_range(0, 15);
      3:       return $urandom_range(0, DEPTH - 1);
      default: return $urandom_range(0, 15);
    endcase
  endfunction

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++)
      drive($urandom_range(0, 9) < 7, rnd_addr(), $urandom_range(0, 1) == 1,
            rnd_addr(), $urandom, 4'($urandom_range(0, 15)));
  endtask

  initial begin
    rst = 1'b1;
    rd_req_valid = 0; rd_addr = '0; wr_valid = 0; wr_addr = '0; wr_data = '0; wr_byte_en = 4'hF;
    tick();
    rst = 1'b0;
    idle(DEPTH + 2);

    drive(1, 5, 0, '0, '0, 4'hF);
    idle(3);
    drive(0, '0, 1, 10, 32'hDEAD_BEEF, 4'hF);
    drive(1, 10, 0, '0, '0, 4'hF);
    idle(3);
    drive(0, '0, 1, 1, 32'h11, 4'hF);
    drive(0, '0, 1, 2, 32'h22, 4'hF);
    drive(0, '0, 1, 3, 32'h33, 4'hF);
    drive(1, 1, 0, '0, '0, 4'hF);
    drive(1, 2, 0, '0, '0, 4'hF);
    drive(1, 3, 0, '0, '0, 4'hF);
    idle(3);
    drive(0, '0, 1, 7, 32'h5, 4'hF);
    drive(1, 7, 1, 7, 32'hAAAA_0000, 4'hF);
    drive(1, 7, 0, '0, '0, 4'hF);
    idle(3);
    drive(1, AW'(DEPTH), 0, '0, '0, 4'hF);
    drive(0, '0, 1, 4096, 32'h1, 4'hF);
    drive(1, 0, 0, '0, '0, 4'hF);
    idle(3);
`ifdef PIPELINED_MAIN_MEMORY_BYTE_WRITE_EN
    drive(0, '0, 1, 20, 32'h1234_5678, 4'hF);
    drive(0, '0, 1, 20, 32'hFFFF_FFFF, 4'b0101);
    drive(1, 20, 1, 20, 32'h0BAD_0BAD, 4'b0000);
    drive(1, 20, 0, '0, '0, 4'hF);
    idle(3);
`endif
    random_traffic(400);

    drive(1, 1, 0, '0, '0, 4'hF);
    drive(1, 2, 1, 3, 32'hCAFE_F00D, 4'hF);
    rst = 1'b1;
    drive(1, 3, 1, 4, 32'h1234_0000, 4'hF);
    rst = 1'b0;
    random_traffic(DEPTH + 2);
    random_traffic(200);
    idle(LAT + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_main_memory.md
Name: pipelined_main_memory

Overview:
- Next-generation main memory for the CPU. Word-addressed storage with DATA_WIDTH x DEPTH words.
- Separate read and write ports with valid/ready request handshakes.
- Read responses come back after a configurable pipeline latency.
- After every reset, the block runs a hardware zero-initialisation sweep before it accepts any request. Out-of-range addresses are flagged, not aliased.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- DEPTH, 2048, number of words; need not be a power of 2.
- ADDR_WIDTH, 32, width of the address ports.
- READ_LATENCY, 2, cycles from an accepted read to rd_resp_valid; legal range is 1 to 4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_req_valid  in  1  read request present.
- rd_req_ready  out  1  read request can be accepted.
- rd_addr  in  ADDR_WIDTH  read word address.
- rd_resp_valid  out  1  read response valid for exactly 1 cycle.
- rd_resp_data  out  DATA_WIDTH  read data.
- rd_resp_err  out  1  the response's address was >= DEPTH.
- wr_valid  in  1  write request present.
- wr_ready  out  1  write can be accepted.
- wr_addr  in  ADDR_WIDTH  write word address.
- wr_data  in  DATA_WIDTH  write data.
- wr_byte_en  in  DATA_WIDTH/8  per-byte write enable; only used with the optional feature.
- init_busy  out  1  zero-initialisation sweep in progress.

Behaviour:
- Reset values while rst is high: rd_req_ready=0, wr_ready=0, rd_resp_valid=0, rd_resp_data=0, rd_resp_err=0, init_busy=1. The init counter is cleared to 0.
- State machine:
  - INIT: writes 0 to mem[init_cnt] each cycle and increments init_cnt. After the cycle that writes DEPTH-1, it moves to RUN. The sweep therefore takes exactly DEPTH cycles after rst deasserts.
  - RUN: rd_req_ready=1, wr_ready=1, init_busy=0. RUN stays RUN until rst.
- Read handshake:
  - A read is accepted when rd_req_valid && rd_req_ready.
  - It produces rd_resp_valid=1 exactly READ_LATENCY cycles later.
  - The read pipeline is fully pipelined: one read per cycle, responses in request order, no response backpressure.
  - In cycles with no response: rd_resp_valid=0, and rd_resp_data/rd_resp_err hold 0.
- Write handshake:
  - A write is accepted when wr_valid && wr_ready. Memory is updated at the end of the accepting cycle.
- Range rules:
  - Out-of-range write (wr_addr >= DEPTH): dropped, memory untouched, no error output.
  - Out-of-range read: rd_resp_data=0 and rd_resp_err=1 in the response cycle.
- Same-address read and write accepted in the same cycle: the read returns the old data (read-first). A read accepted 1 or more cycles after the write returns the new data.
- Reset mid-operation:
  - All in-flight read responses are discarded; no rd_resp_valid after rst.
  - Writes in the rst cycle are ignored.
  - The INIT sweep restarts from 0.
- Address compare uses the full ADDR_WIDTH; there is no truncation or aliasing.

Optional Feature:
- Macro: PIPELINED_MAIN_MEMORY_BYTE_WRITE_EN.
- Defined: only bytes with wr_byte_en[i]=1 are written (bits 8i+7..8i). A write with wr_byte_en all zero is accepted but changes nothing.
- Undefined: wr_byte_en is ignored and every accepted write updates the full word. The port remains present so the interface is identical.

Test Plan:
- Reset for 1 cycle, then wait: init_busy=1 for exactly DEPTH cycles, rd_req_ready/wr_ready=0 during the sweep, then both are 1. A read of address 5 returns 0 with err=0.
- Write 0xDEADBEEF to address 10, then read address 10 on the next cycle (READ_LATENCY=2): rd_resp_valid is high 2 cycles after acceptance with data 0xDEADBEEF.
- Back-to-back reads of addresses 1, 2, 3 after writing 0x11, 0x22, 0x33: three consecutive responses 0x11, 0x22, 0x33, in order.
- Same cycle: write 0xAAAA0000 to address 7 (old value 0x5) and read address 7: response is 0x5. A read on the following cycle returns 0xAAAA0000.
- Read address DEPTH (2048): rd_resp_err=1, data=0. Write 0x1 to address 4096: memory unchanged, no error.
- Two reads in flight, then assert rst: no rd_resp_valid for either read. The INIT sweep restarts and init_busy=1 for DEPTH cycles.
- With the macro defined: word holds 0x12345678; write 0xFFFFFFFF with wr_byte_en=4'b0101; a read returns 0x12FF56FF.
